program_load_controller: RTL and testbench
==========================================

// Module: program_load_controller
// PURPOSE
//  Sequencer for the pipelined RISC-V core. It loads a byte stream into program memory
//  through the core's pmWrEn / pm_addr / instructionIn ports. It holds the core in reset
//  while loading, then releases it for a programmed number of cycles and captures alu_result.
//  Sits between the host/stream source and the CPU top level.
// PARAMETERS
//  ADD_WIDTH   7   program-memory address width (depth = 2**ADD_WIDTH bytes)
//  DATA_WIDTH  8   program-memory write width and alu_result width
//  CYC_WIDTH   16  width of the run-cycle counter
//  RST_CYCLES  2   cycles cpu_rst stays high after the last write (pipeline flush), >=1
// PORTS
//  clk          in   1            clock
//  rst          in   1            synchronous reset, active-high
//  start        in   1            start request; sampled only in IDLE
//  load_len     in   ADD_WIDTH+1  bytes to load; legal range 1..2**ADD_WIDTH
//  run_cycles   in   CYC_WIDTH    cycles to run the core; legal range >=1
//  abort        in   1            cancel the current operation
//  s_valid      in   1            stream byte valid
//  s_data       in   DATA_WIDTH   stream byte
//  s_ready      out  1            stream ready
//  pm_wr_en     out  1            to CPU pmWrEn
//  pm_addr      out  ADD_WIDTH    to CPU pm_addr
//  pm_wr_data   out  DATA_WIDTH   to CPU instructionIn
//  cpu_rst      out  1            to CPU rst
//  alu_result   in   DATA_WIDTH   from CPU alu_result
//  result       out  DATA_WIDTH   captured alu_result
//  result_valid out  1            one-cycle pulse when result is updated
//  busy         out  1            state != IDLE
//  err          out  1            sticky: illegal start parameters
// BEHAVIOUR
//  Reset: state=IDLE, cpu_rst=1. All other outputs are 0, and all counters are 0.
//  States:
//   - IDLE: cpu_rst=1.
//     * start with legal load_len and run_cycles: latch both, clear addr counter, clear err -> LOAD.
//     * start with load_len=0, load_len>2**ADD_WIDTH or run_cycles=0: stay IDLE, err=1 from next cycle.
//     * err stays set until the next accepted start.
//   - LOAD: s_ready = (state==LOAD) & ~abort, decoded from the state register.
//     * Transfer = s_valid & s_ready; at most one byte per cycle.
//     * Each transfer registers a write: in the next cycle pm_wr_en=1 for exactly one cycle,
//       pm_addr=addr counter, pm_wr_data=s_data. The addr counter then increments.
//     * A transfer of byte load_len-1 -> FLUSH. That byte's write occurs in the first FLUSH cycle.
//     * Gaps in s_valid produce no writes; addresses stay contiguous from 0.
//     * load_len=2**ADD_WIDTH ends at the last address (all ones) with no wrap. The counter
//       never wraps within a load.
//   - FLUSH: cpu_rst=1 for exactly RST_CYCLES cycles, then -> RUN.
//   - RUN: cpu_rst=0; the cycle counter counts from 0.
//     * On the clock edge ending cycle run_cycles-1: result<=alu_result (value in that last cycle),
//       result_valid=1 next cycle for one cycle, cpu_rst=1, -> IDLE.
//     * cpu_rst is therefore low for exactly run_cycles cycles.
//  abort (any non-IDLE state):
//   - Next state is IDLE with cpu_rst=1.
//   - No transfer is accepted in the abort cycle.
//   - No result_valid is produced and result keeps its old value.
//   - A write registered from the previous cycle's transfer still completes.
//   - abort in IDLE is ignored.
//  Priority: rst > abort > normal transitions. start while busy is ignored.
//  rst mid-operation returns to the reset values. Program-memory contents are not altered.
//  All outputs are registered except s_ready and busy, which are decoded from the state register.
// TESTING
//  1. rst high 2 cycles -> cpu_rst=1, s_ready=0, busy=0, pm_wr_en=0, result=0, err=0.
//  2. start, len=8, run_cycles=20, bytes 0x10..0x17 back-to-back -> 8 consecutive pm_wr_en
//     cycles at addr 0..7 with data 0x10..0x17; cpu_rst high 2 cycles after the last write,
//     then low exactly 20 cycles; alu_result=0x5A in the last cycle -> result=0x5A,
//     one-cycle result_valid.
//  3. len=4 with s_valid toggling 1,0,0,1,1,0,1 -> 4 writes at addr 0..3, only on transfers, then FLUSH.
//  4. start with len=0, then len=129, then run_cycles=0 -> busy stays 0 and err=1 each time;
//     a legal start clears err.
//  5. len=128 -> 128 writes, last at addr 0x7F, no wrap; s_ready low after the 128th transfer.
//  6. abort after 3 transfers with s_valid high -> s_ready=0 in the abort cycle, exactly 3 writes,
//     IDLE next cycle with cpu_rst=1; abort in RUN cycle 5 -> no result_valid.
//     start in LOAD is ignored.

Source files
------------

// File: rtl/program_load_controller.sv
// Program-load sequencer: streams bytes into the core's program memory while holding it
// in reset, flushes the pipeline, runs the core for a set number of cycles, then captures alu_result.
module program_load_controller #(
  parameter int ADD_WIDTH  = 7,
  parameter int DATA_WIDTH = 8,
  parameter int CYC_WIDTH  = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADD_WIDTH:0]    load_len,
  input  logic [CYC_WIDTH-1:0]  run_cycles,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  pm_wr_en,
  output logic [ADD_WIDTH-1:0]  pm_addr,
  output logic [DATA_WIDTH-1:0] pm_wr_data,
  output logic                  cpu_rst,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  err
);

  localparam int LEN_WIDTH = ADD_WIDTH + 1;
  localparam int FL_WIDTH  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = {1'b1, {ADD_WIDTH{1'b0}}};
  localparam logic [FL_WIDTH-1:0]  FL_LAST = FL_WIDTH'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] addr_cnt;
  logic [CYC_WIDTH-1:0] run_q;
  logic [CYC_WIDTH-1:0] cyc_cnt;
  logic [FL_WIDTH-1:0]  fl_cnt;
  logic                 xfer;
  logic                 start_ok;

  // abort masks ready in the same cycle so no byte is taken while cancelling
  assign s_ready  = (state == LOAD) && !abort;
  assign busy     = (state != IDLE);
  assign xfer     = s_valid && s_ready;
  assign start_ok = (load_len != {LEN_WIDTH{1'b0}}) && (load_len <= MAX_LEN) &&
                    (run_cycles != {CYC_WIDTH{1'b0}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len_q        <= '0;
      addr_cnt     <= '0;
      run_q        <= '0;
      cyc_cnt      <= '0;
      fl_cnt       <= '0;
      pm_wr_en     <= 1'b0;
      pm_addr      <= '0;
      pm_wr_data   <= '0;
      cpu_rst      <= 1'b1;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      // a transfer becomes a write one cycle later, even if abort follows
      pm_wr_en     <= xfer;
      result_valid <= 1'b0;
      if (xfer) begin
        pm_addr    <= addr_cnt[ADD_WIDTH-1:0];
        pm_wr_data <= s_data;
        addr_cnt   <= addr_cnt + LEN_WIDTH'(1);
      end
      if (busy && abort) begin
        state   <= IDLE;
        cpu_rst <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            cpu_rst <= 1'b1;
            if (start) begin
              if (start_ok) begin
                len_q    <= load_len;
                run_q    <= run_cycles;
                addr_cnt <= '0;
                fl_cnt   <= '0;
                cyc_cnt  <= '0;
                err      <= 1'b0;
                state    <= LOAD;
              end else begin
                err <= 1'b1;
              end
            end
          end
          LOAD: begin
            if (xfer && (addr_cnt == len_q - LEN_WIDTH'(1))) begin
              fl_cnt <= '0;
              state  <= FLUSH;
            end
          end
          FLUSH: begin
            if (fl_cnt == FL_LAST) begin
              cpu_rst <= 1'b0;
              cyc_cnt <= '0;
              state   <= RUN;
            end else begin
              fl_cnt <= fl_cnt + FL_WIDTH'(1);
            end
          end
          RUN: begin
            if (cyc_cnt == run_q - CYC_WIDTH'(1)) begin
              result       <= alu_result;
              result_valid <= 1'b1;
              cpu_rst      <= 1'b1;
              state        <= IDLE;
            end else begin
              cyc_cnt <= cyc_cnt + CYC_WIDTH'(1);
            end
          end
          default: begin
            cpu_rst <= 1'b1;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_load_controller.sv
// Self-checking bench for program_load_controller: start-legality table, directed
// multi-cycle sequences and randomized loads checked against a transaction-level model.
module tb_program_load_controller;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          rst, start, abort, s_valid;
  logic [AW:0]   load_len;
  logic [CW-1:0] run_cycles;
  logic [DW-1:0] s_data, alu_result;
  logic          s_ready, pm_wr_en, cpu_rst, result_valid, busy, err;
  logic [AW-1:0] pm_addr;
  logic [DW-1:0] pm_wr_data, result;

  int checks = 0;
  int errors = 0;

  program_load_controller #(.ADD_WIDTH(AW), .DATA_WIDTH(DW), .CYC_WIDTH(CW), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len), .run_cycles(run_cycles),
    .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .pm_wr_en(pm_wr_en), .pm_addr(pm_addr), .pm_wr_data(pm_wr_data), .cpu_rst(cpu_rst),
    .alu_result(alu_result), .result(result), .result_valid(result_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  bit alu_fixed = 1'b0;
  always @(posedge clk) begin
    #2;
    alu_result = alu_fixed ? 8'h5A : 8'($urandom);
  end

  // Observed-event log: writes, cpu_rst low cycles, result pulses
  int            cyc = 0, low_total = 0, rv_total = 0;
  int            last_low_cyc = 0, first_low_cyc = 0, rv_last_cyc = 0;
  logic [DW-1:0] last_alu_low = '0, rv_last_val = '0;
  logic          prev_cpu_rst = 1'b1;
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int            wr_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (pm_wr_en === 1'b1) begin
      wr_addr.push_back(pm_addr);
      wr_data.push_back(pm_wr_data);
      wr_cyc.push_back(cyc);
    end
    if (cpu_rst === 1'b0) begin
      low_total++;
      last_low_cyc = cyc;
      last_alu_low = alu_result;
      if (prev_cpu_rst === 1'b1) first_low_cyc = cyc;
    end
    if (result_valid === 1'b1) begin
      rv_total++;
      rv_last_cyc = cyc;
      rv_last_val = result;
    end
    prev_cpu_rst = cpu_rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [DW-1:0] model_res = '0;

  // Full load/flush/run operation; mode 0 = back-to-back, 1 = random valid, 2 = fixed gap pattern
  task automatic do_op(input int len, input int runc, input int mode, input bit fixed_data,
                       input string tag);
    logic [DW-1:0] bytes[$];
    logic [6:0]    pat;
    int            base_w, base_low, base_rv, sent, i, j, n, badr, badw;
    bit            v;
    pat = 7'b1011001;
    for (int k = 0; k < len; k++) bytes.push_back(fixed_data ? 8'(8'h10 + k) : 8'($urandom));
    base_w = wr_addr.size(); base_low = low_total; base_rv = rv_total;
    start = 1'b1; load_len = len[AW:0]; run_cycles = runc[CW-1:0];
    tick();
    start = 1'b0;
    check({tag, "_accept_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_accept_err"}, {31'd0, err}, 32'd0);
    sent = 0; i = 0; badr = 0;
    while (sent < len && i < 4000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : pat[i % 7];
      s_valid = v;
      s_data  = bytes[sent];
      #1;
      if (s_ready !== 1'b1) badr++;
      tick();
      if (v) sent++;
      i++;
    end
    s_valid = 1'b0;
    #1;
    check({tag, "_ready_during_load"}, badr, 32'd0);
    check({tag, "_ready_after_last"}, {31'd0, s_ready}, 32'd0);
    j = 0;
    while (busy === 1'b1 && j < runc + RC + 20) begin
      tick();
      j++;
    end
    check({tag, "_done_timeout"}, {31'd0, busy}, 32'd0);
    tick();
    n = wr_addr.size() - base_w;
    check({tag, "_num_writes"}, n, len);
    badw = 0;
    for (int k = 0; k < n && k < len; k++)
      if (wr_addr[base_w + k] !== k[AW-1:0] || wr_data[base_w + k] !== bytes[k]) badw++;
    check({tag, "_write_content"}, badw, 32'd0);
    if (n > 0) check({tag, "_flush_len"}, first_low_cyc - wr_cyc[wr_cyc.size() - 1], RC);
    check({tag, "_run_len"}, low_total - base_low, runc);
    check({tag, "_rv_pulses"}, rv_total - base_rv, 32'd1);
    check({tag, "_rv_timing"}, rv_last_cyc, last_low_cyc + 1);
    check({tag, "_rv_value"}, rv_last_val, last_alu_low);
    check({tag, "_result"}, result, last_alu_low);
    check({tag, "_cpu_rst_idle"}, {31'd0, cpu_rst}, 32'd1);
    model_res = last_alu_low;
  endtask

  typedef struct {
    logic [AW:0]   len;
    logic [CW-1:0] runc;
    logic          exp_busy;
    logic          exp_err;
  } vec_t;
  vec_t tbl[7];

  int base_w, base_rv, base_low, j;

  initial begin
    tbl[0] = '{8'd0,   16'd5, 1'b0, 1'b1};
    tbl[1] = '{8'd129, 16'd5, 1'b0, 1'b1};
    tbl[2] = '{8'd1,   16'd3, 1'b1, 1'b0};
    tbl[3] = '{8'd255, 16'd9, 1'b0, 1'b1};
    tbl[4] = '{8'd8,   16'd0, 1'b0, 1'b1};
    tbl[5] = '{8'd128, 16'd1, 1'b1, 1'b0};
    tbl[6] = '{8'd0,   16'd0, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    load_len = '0; run_cycles = '0;
    tick(); tick();
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pm_wr_en", {31'd0, pm_wr_en}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_result_valid", {31'd0, result_valid}, 32'd0);
    rst = 1'b0;
    tick();

    alu_fixed = 1'b1;
    do_op(8, 20, 0, 1'b1, "basic");
    check("basic_result_5a", result, 32'h5A);
    alu_fixed = 1'b0;

    do_op(4, 7, 2, 1'b0, "gaps");

    for (int i = 0; i < 7; i++) begin
      start = 1'b1; load_len = tbl[i].len; run_cycles = tbl[i].runc;
      tick();
      start = 1'b0;
      check($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].exp_busy});
      check($sformatf("tbl%0d_err", i), {31'd0, err}, {31'd0, tbl[i].exp_err});
      if (tbl[i].exp_busy) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check($sformatf("tbl%0d_abort_idle", i), {31'd0, busy}, 32'd0);
      end
    end

    do_op(128, 3, 0, 1'b0, "full");

    // abort in LOAD after three transfers; a start while loading must be ignored
    base_w = wr_addr.size(); base_rv = rv_total;
    start = 1'b1; load_len = 8'd8; run_cycles = 16'd20;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = 8'(8'hA0 + k);
      if (k == 1) begin start = 1'b1; load_len = 8'd2; end
      tick();
      start = 1'b0;
    end
    check("load_start_ignored_busy", {31'd0, busy}, 32'd1);
    check("load_start_ignored_ready", {31'd0, s_ready}, 32'd1);
    abort = 1'b1;
    #1;
    check("abort_ready_low", {31'd0, s_ready}, 32'd0);
    tick();
    abort = 1'b0; s_valid = 1'b0;
    check("abort_load_idle", {31'd0, busy}, 32'd0);
    check("abort_load_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    repeat (3) tick();
    check("abort_load_writes", wr_addr.size() - base_w, 32'd3);
    check("abort_load_last_addr", wr_addr[wr_addr.size() - 1], 32'd2);
    check("abort_load_no_rv", rv_total - base_rv, 32'd0);

    // abort in RUN cycle 5
    base_rv = rv_total;
    start = 1'b1; load_len = 8'd1; run_cycles = 16'd20;
    tick();
    start = 1'b0; s_valid = 1'b1; s_data = 8'h33;
    tick();
    s_valid = 1'b0;
    base_low = low_total;
    j = 0;
    while (cpu_rst === 1'b1 && j < 20) begin
      tick();
      j++;
    end
    check("run_entered", {31'd0, cpu_rst}, 32'd0);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_run_idle", {31'd0, busy}, 32'd0);
    check("abort_run_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    repeat (3) tick();
    check("abort_run_no_rv", rv_total - base_rv, 32'd0);
    check("abort_run_result_kept", result, model_res);
    check("abort_run_low_cycles", low_total - base_low, 32'd6);

    repeat (6) do_op($urandom_range(1, 128), $urandom_range(1, 40), 1, 1'b0, "rnd");

    // synchronous reset in the middle of a load
    start = 1'b1; load_len = 8'd8; run_cycles = 16'd5;
    tick();
    start = 1'b0; s_valid = 1'b1; s_data = 8'h77;
    tick(); tick();
    s_valid = 1'b0; rst = 1'b1;
    tick();
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("midrst_pm_wr_en", {31'd0, pm_wr_en}, 32'd0);
    check("midrst_result", result, 32'd0);
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
